fifo_counted: RTL and testbench

Parametrised synchronous FIFO, the next generation of the PE-array operand FIFO. It uses all DEPTH entries, where the previous generation lost one slot. It adds occupancy count, programmable almost-full/almost-empty thresholds, pop-while-full pass-through, synchronous flush, and sticky overflow/underflow error flags. It sits between the operand loaders and the systolic array edge, one instance per row/column feed.

---
 rtl/fifo_counted_if.sv | 29 ++
 rtl/fifo_counted.sv | 104 ++++++++++
 tb/tb_fifo_counted.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/fifo_counted_if.sv
// Handshake bundle between an operand loader (master) and a fifo_counted instance (slave).
// Width parameters must match the ones given to the attached fifo_counted.
interface fifo_counted_if #(
    parameter int unsigned BWIDTH     = 8,
    parameter int unsigned DEPTH_LOG2 = 5
);
    logic                  CLR;
    logic                  PUSHE;
    logic                  POPE;
    logic [BWIDTH-1:0]     D_in;
    logic [BWIDTH-1:0]     D_out;
    logic                  IS_EMPTY;
    logic                  IS_FULL;
    logic                  ALMOST_FULL;
    logic                  ALMOST_EMPTY;
    logic [DEPTH_LOG2:0]   COUNT;
    logic                  OVF;
    logic                  UDF;

    modport master (
        output CLR, PUSHE, POPE, D_in,
        input  D_out, IS_EMPTY, IS_FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVF, UDF
    );

    modport slave (
        input  CLR, PUSHE, POPE, D_in,
        output D_out, IS_EMPTY, IS_FULL, ALMOST_FULL, ALMOST_EMPTY, COUNT, OVF, UDF
    );
endinterface

// File: rtl/fifo_counted.sv
// Show-ahead synchronous FIFO using all DEPTH slots, with registered occupancy count,
// almost-full/empty thresholds, pop-while-full pass-through, flush and sticky error flags.
module fifo_counted #(
    parameter int unsigned BWIDTH     = 8,
    parameter int unsigned DEPTH      = 32,
    parameter int unsigned DEPTH_LOG2 = 5,
    parameter int unsigned AF_THRESH  = DEPTH - 4,
    parameter int unsigned AE_THRESH  = 4
) (
    input logic           CLK,
    input logic           RSTn,
    fifo_counted_if.slave fifo_io
);
    localparam int unsigned PtrW = DEPTH_LOG2 + 1;
    typedef logic [PtrW-1:0] ptr_t;

    localparam ptr_t DepthCnt = ptr_t'(DEPTH);
    localparam ptr_t AfCnt    = ptr_t'(AF_THRESH);
    localparam ptr_t AeCnt    = ptr_t'(AE_THRESH);

    ptr_t front_q, front_d;
    ptr_t rear_q, rear_d;
    ptr_t count_q, count_d;
    logic ovf_q, ovf_d;
    logic udf_q, udf_d;

    logic is_empty, is_full;
    logic pop_ok, push_ok;

    logic [BWIDTH-1:0] mem_q [DEPTH];

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == DepthCnt);

    // A full FIFO still accepts a push when a pop frees the head in the same cycle.
    assign pop_ok  = fifo_io.POPE & ~is_empty;
    assign push_ok = fifo_io.PUSHE & (~is_full | pop_ok);

    always_comb begin
        front_d = front_q;
        rear_d  = rear_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        udf_d   = udf_q;
        if (fifo_io.CLR) begin
            front_d = '0;
            rear_d  = '0;
            count_d = '0;
            ovf_d   = 1'b0;
            udf_d   = 1'b0;
        end else begin
            if (push_ok) begin
                rear_d = rear_q + ptr_t'(1);
            end
            if (pop_ok) begin
                front_d = front_q + ptr_t'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + ptr_t'(1);
                2'b01:   count_d = count_q - ptr_t'(1);
                default: count_d = count_q;
            endcase
            ovf_d = ovf_q | (fifo_io.PUSHE & ~push_ok);
            udf_d = udf_q | (fifo_io.POPE & is_empty);
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            front_q <= '0;
            rear_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            front_q <= front_d;
            rear_q  <= rear_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    // Storage is deliberately left out of reset and flush.
    always_ff @(posedge CLK) begin
        if (push_ok && !fifo_io.CLR) begin
            mem_q[rear_q[DEPTH_LOG2-1:0]] <= fifo_io.D_in;
        end
    end

    assign fifo_io.D_out        = mem_q[front_q[DEPTH_LOG2-1:0]];
    assign fifo_io.IS_EMPTY     = is_empty;
    assign fifo_io.IS_FULL      = is_full;
    assign fifo_io.ALMOST_FULL  = (count_q >= AfCnt);
    assign fifo_io.ALMOST_EMPTY = (count_q <= AeCnt);
    assign fifo_io.COUNT        = count_q;
    assign fifo_io.OVF          = ovf_q;
    assign fifo_io.UDF          = udf_q;

    // The count register is redundant with the pointers; they must never diverge.
    count_matches_ptrs: assert property (@(posedge CLK) disable iff (!RSTn)
        count_q == ptr_t'(rear_q - front_q));

endmodule

// File: tb/tb_fifo_counted.sv
// Self-checking bench for fifo_counted: directed vector table, hand-written corner
// sequences and a randomised run against a queue scoreboard with an async reset pulse.
module tb_fifo_counted;
    localparam int unsigned BW    = 8;
    localparam int unsigned DEPTH = 32;
    localparam int unsigned DL2   = 5;
    localparam int unsigned AF    = DEPTH - 4;
    localparam int unsigned AE    = 4;

    logic CLK  = 1'b0;
    logic RSTn = 1'b0;

    fifo_counted_if #(.BWIDTH(BW), .DEPTH_LOG2(DL2)) bus_if ();

    fifo_counted #(
        .BWIDTH    (BW),
        .DEPTH     (DEPTH),
        .DEPTH_LOG2(DL2),
        .AF_THRESH (AF),
        .AE_THRESH (AE)
    ) dut (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .fifo_io(bus_if)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       push;
        logic       pop;
        logic [7:0] din;
        int         cnt;
        logic       empty;
        logic       full;
        logic       af;
        logic       ae;
        logic       ovf;
        logic       udf;
        logic       chk_dout;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs[$];

    logic [7:0] q[$];
    logic mdl_ovf = 1'b0;
    logic mdl_udf = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic push, input logic pop, input logic [7:0] din,
                                input int cnt, input logic ovf, input logic udf,
                                input logic chk_d, input logic [7:0] dout);
        vec_t v;
        v.push     = push;
        v.pop      = pop;
        v.din      = din;
        v.cnt      = cnt;
        v.empty    = (cnt == 0);
        v.full     = (cnt == 32);
        v.af       = (cnt >= 28);
        v.ae       = (cnt <= 4);
        v.ovf      = ovf;
        v.udf      = udf;
        v.chk_dout = chk_d;
        v.dout     = dout;
        return v;
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic push, input logic pop, input logic clr,
                         input logic [7:0] din);
        bus_if.PUSHE = push;
        bus_if.POPE  = pop;
        bus_if.CLR   = clr;
        bus_if.D_in  = din;
    endtask

    task automatic chk_status(input string tag, input int cnt, input logic ovf,
                              input logic udf);
        chk({tag, " COUNT"},        32'(bus_if.COUNT),        32'(cnt));
        chk({tag, " IS_EMPTY"},     32'(bus_if.IS_EMPTY),     32'(cnt == 0));
        chk({tag, " IS_FULL"},      32'(bus_if.IS_FULL),      32'(cnt == int'(DEPTH)));
        chk({tag, " ALMOST_FULL"},  32'(bus_if.ALMOST_FULL),  32'(cnt >= int'(AF)));
        chk({tag, " ALMOST_EMPTY"}, 32'(bus_if.ALMOST_EMPTY), 32'(cnt <= int'(AE)));
        chk({tag, " OVF"},          32'(bus_if.OVF),          32'(ovf));
        chk({tag, " UDF"},          32'(bus_if.UDF),          32'(udf));
    endtask

    // One clock of stimulus with scoreboard: head checked before the edge, status after.
    task automatic cycle(input logic push, input logic pop, input logic clr,
                         input logic [7:0] din, input string tag);
        logic m_empty, m_full, m_pop_ok, m_push_ok;
        drive(push, pop, clr, din);
        if (q.size() > 0) chk({tag, " D_out"}, 32'(bus_if.D_out), 32'(q[0]));
        m_empty   = (q.size() == 0);
        m_full    = (q.size() == int'(DEPTH));
        m_pop_ok  = pop && !m_empty;
        m_push_ok = push && (!m_full || m_pop_ok);
        tick();
        if (clr) begin
            q.delete();
            mdl_ovf = 1'b0;
            mdl_udf = 1'b0;
        end else begin
            if (m_pop_ok) void'(q.pop_front());
            if (m_push_ok) q.push_back(din);
            if (push && !m_push_ok) mdl_ovf = 1'b1;
            if (pop && m_empty) mdl_udf = 1'b1;
        end
        chk_status(tag, q.size(), mdl_ovf, mdl_udf);
    endtask

    initial begin
        int rst_at;
        int pct;

        // Fill 32, overflow push, drain 32, underflow pop.
        for (int i = 1; i <= 32; i++) vecs.push_back(mk(1, 0, 8'(i), i, 0, 0, 1, 8'h01));
        vecs.push_back(mk(1, 0, 8'h99, 32, 1, 0, 1, 8'h01));
        for (int k = 1; k <= 32; k++)
            vecs.push_back(mk(0, 1, 8'h00, 32 - k, 1, 0, k < 32, 8'(k + 1)));
        vecs.push_back(mk(0, 1, 8'h00, 0, 1, 1, 0, 8'h00));

        drive(0, 0, 0, 8'h00);
        #12;
        chk_status("reset", 0, 0, 0);
        RSTn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            string tag;
            tag = $sformatf("vec%0d", i);
            drive(vecs[i].push, vecs[i].pop, 1'b0, vecs[i].din);
            tick();
            chk({tag, " COUNT"},        32'(bus_if.COUNT),        32'(vecs[i].cnt));
            chk({tag, " IS_EMPTY"},     32'(bus_if.IS_EMPTY),     32'(vecs[i].empty));
            chk({tag, " IS_FULL"},      32'(bus_if.IS_FULL),      32'(vecs[i].full));
            chk({tag, " ALMOST_FULL"},  32'(bus_if.ALMOST_FULL),  32'(vecs[i].af));
            chk({tag, " ALMOST_EMPTY"}, 32'(bus_if.ALMOST_EMPTY), 32'(vecs[i].ae));
            chk({tag, " OVF"},          32'(bus_if.OVF),          32'(vecs[i].ovf));
            chk({tag, " UDF"},          32'(bus_if.UDF),          32'(vecs[i].udf));
            if (vecs[i].chk_dout) chk({tag, " D_out"}, 32'(bus_if.D_out), 32'(vecs[i].dout));
        end

        // Pass-through while full: count holds, order preserved, 0xAA surfaces after 32 pops.
        cycle(0, 0, 1, 8'h00, "pt_clr");
        for (int i = 1; i <= 32; i++) cycle(1, 0, 0, 8'(i), "pt_fill");
        for (int i = 0; i < 40; i++) cycle(1, 1, 0, 8'hAA, "pt");
        chk("pt head_is_AA", 32'(bus_if.D_out), 32'h0000_00AA);

        // Empty with simultaneous push/pop: push wins, pop flagged as underflow.
        cycle(0, 0, 1, 8'h00, "epp_clr");
        cycle(1, 1, 0, 8'h55, "epp");
        chk("epp D_out", 32'(bus_if.D_out), 32'h0000_0055);

        // Flush with push pending and both error flags set.
        cycle(0, 0, 1, 8'h00, "fl_clr");
        for (int i = 0; i < 33; i++) cycle(1, 0, 0, 8'(i + 8'h40), "fl_fill");
        for (int i = 0; i < 33; i++) cycle(0, 1, 0, 8'h00, "fl_drain");
        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 8'(i + 8'h60), "fl_ten");
        cycle(1, 0, 1, 8'h77, "fl_clrpush");
        cycle(1, 0, 0, 8'h33, "fl_after");
        chk("fl_after D_out", 32'(bus_if.D_out), 32'h0000_0033);

        // Randomised traffic with drifting push/pop bias and one async reset pulse.
        rst_at = $urandom_range(2000, 8000);
        pct    = 50;
        for (int c = 0; c < 10000; c++) begin
            logic rp, rpo, rc;
            if (c % 256 == 0) pct = $urandom_range(20, 80);
            if (c == rst_at) begin
                #2;
                RSTn = 1'b0;
                #1;
                q.delete();
                mdl_ovf = 1'b0;
                mdl_udf = 1'b0;
                chk_status("async_rst", 0, 0, 0);
                #1;
                RSTn = 1'b1;
            end
            rp  = ($urandom_range(99) < pct);
            rpo = ($urandom_range(99) < (100 - pct));
            rc  = ($urandom_range(999) == 0);
            cycle(rp, rpo, rc, 8'($urandom), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
